// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, idle-high line.
// Samples each bit at mid-period from a two-flop synchronised copy of rxd and
// hands complete bytes to the consumer through a valid/ack level handshake.
// A stop bit sampled low raises a one-cycle frame_err and the byte is dropped;
// a byte landing on top of an unconsumed one sets the sticky overrun flag.
module uart_rx #(
    parameter int BIT_TMR_MAX = 869
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       ack,
    output logic [7:0] data_rx,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF_BIT = BIT_TMR_MAX / 2;
    localparam int TW       = $clog2(BIT_TMR_MAX + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_TMR_MAX - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic          rxd_meta;
    logic          rxd_s;
    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          tick;
    logic          load;
    logic          bad_stop;

    // Two-flop synchroniser; both flops reset to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // Sample event: half a bit into the start bit, a full bit for data and stop.
    always_comb begin
        tick = 1'b0;
        case (state)
            ST_START:         tick = (timer == HALF_LAST);
            ST_DATA, ST_STOP: tick = (timer == BIT_LAST);
            default:          tick = 1'b0;
        endcase
    end

    assign load     = (state == ST_STOP) && tick && rxd_s;
    assign bad_stop = (state == ST_STOP) && tick && !rxd_s;
    assign busy     = (state != ST_IDLE);

    // Frame FSM with bit timer, bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            timer <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            if (state == ST_IDLE || state == ST_BREAK || tick)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    if (!rxd_s)
                        state <= ST_START;
                end
                ST_START: begin
                    if (tick)
                        state <= rxd_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (tick) begin
                        shift <= {rxd_s, shift[7:1]};
                        if (idx == 3'd7) begin
                            idx   <= '0;
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick)
                        state <= rxd_s ? ST_IDLE : ST_BREAK;
                end
                ST_BREAK: begin
                    // A line held low (break) must go high before a new frame can start.
                    if (rxd_s)
                        state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register: byte hand-off, ack/overrun bookkeeping and frame_err pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_rx   <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            if (load) begin
                // A simultaneous ack consumes the old byte, so overrun is left alone.
                data_rx <= shift;
                valid   <= 1'b1;
                if (valid && !ack)
                    overrun <= 1'b1;
            end else if (valid && ack) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with BIT_TMR_MAX = 16.
module tb_uart_rx;

    localparam int N = 16;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       ack;
    logic [7:0] data_rx;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    logic       ack_man;
    logic       ack_auto;
    logic       auto_en;

    int n_cmp;
    int n_bad;
    int vrise_cnt;
    int ferr_cnt;
    int ncap;
    logic [7:0] cap [0:15];
    logic valid_q;

    int base_v;
    int base_f;
    int base_c;

    uart_rx #(.BIT_TMR_MAX(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .ack       (ack),
        .data_rx   (data_rx),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ack = ack_man | ack_auto;

    // Consumer model used for back-to-back frames: acks any valid byte.
    always @(negedge clk) ack_auto = auto_en && valid;

    // Event monitor: valid rises, frame_err pulses, bytes consumed.
    always @(posedge clk) begin
        if (valid && !valid_q) vrise_cnt <= vrise_cnt + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (ack && valid && ncap < 16) begin
            cap[ncap] <= data_rx;
            ncap      <= ncap + 1;
        end
        valid_q <= valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clk(N);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        rxd = 1'b1;
    endtask

    task automatic ack_pulse();
        ack_man = 1'b1;
        wait_clk(1);
        ack_man = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        vrise_cnt = 0; ferr_cnt = 0; ncap = 0; valid_q = 1'b0;
        ack_man = 1'b0; ack_auto = 1'b0; auto_en = 1'b0;
        rxd = 1'b1;
        rst = 1'b1;

        // Reset state
        wait_clk(3);
        check("rst_data", data_rx, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        wait_clk(4);

        // Single byte 0xA5
        base_v = vrise_cnt; base_f = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        wait_clk(2);
        check("a5_valid", valid, 1'b1);
        check("a5_data", data_rx, 8'hA5);
        check("a5_rises", vrise_cnt - base_v, 1);
        check("a5_ferr", ferr_cnt - base_f, 0);
        check("a5_busy", busy, 1'b0);
        ack_pulse();
        check("a5_ack_valid", valid, 1'b0);

        // Back-to-back 0x00, 0xFF with the consumer acking each byte
        base_c = ncap;
        auto_en = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clk(4);
        auto_en = 1'b0;
        wait_clk(1);
        check("b2b_count", ncap - base_c, 2);
        check("b2b_byte0", cap[base_c], 8'h00);
        check("b2b_byte1", cap[base_c + 1], 8'hFF);
        check("b2b_ovr", overrun, 1'b0);
        check("b2b_valid", valid, 1'b0);

        // Overrun: 0x3C then 0xC3 without ack
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        wait_clk(2);
        check("ovr_data", data_rx, 8'hC3);
        check("ovr_valid", valid, 1'b1);
        check("ovr_flag", overrun, 1'b1);
        ack_pulse();
        check("ovr_ack_valid", valid, 1'b0);
        check("ovr_ack_flag", overrun, 1'b0);

        // Start-bit glitch: low for 4 clk only
        base_v = vrise_cnt; base_f = ferr_cnt;
        rxd = 1'b0;
        wait_clk(4);
        rxd = 1'b1;
        wait_clk(1);
        check("glitch_busy_mid", busy, 1'b1);
        wait_clk(20);
        check("glitch_busy", busy, 1'b0);
        check("glitch_valid", valid, 1'b0);
        check("glitch_rises", vrise_cnt - base_v, 0);
        check("glitch_ferr", ferr_cnt - base_f, 0);

        // Framing error: 0x55 with stop=0, line held low 40 clk after the data bits
        base_v = vrise_cnt; base_f = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h55 >> i) & 8'h01) != 0);
        rxd = 1'b0;
        wait_clk(40);
        check("fe_pulses", ferr_cnt - base_f, 1);
        check("fe_valid", valid, 1'b0);
        check("fe_rises", vrise_cnt - base_v, 0);
        check("fe_busy_low", busy, 1'b1);
        rxd = 1'b1;
        wait_clk(4);
        check("fe_busy_released", busy, 1'b0);
        send_frame(8'h12, 1'b1);
        wait_clk(2);
        check("fe_next_data", data_rx, 8'h12);
        check("fe_next_valid", valid, 1'b1);
        ack_pulse();

        // Reset in the middle of the data bits of 0x81
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(((8'h81 >> i) & 8'h01) != 0);
        check("mid_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_data", data_rx, 8'h00);
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        check("mid_rst_ferr", frame_err, 1'b0);
        rxd = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);
        base_v = vrise_cnt;
        send_frame(8'h7E, 1'b1);
        wait_clk(2);
        check("post_rst_data", data_rx, 8'h7E);
        check("post_rst_valid", valid, 1'b1);
        check("post_rst_rises", vrise_cnt - base_v, 1);
        ack_pulse();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
